// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM subsystem: register map, ctrl bit positions
// and the ramp sequencer state encoding.
package pwm_pkg;

  localparam logic [15:0] REG_CTRL = 16'h0000;
  localparam logic [15:0] REG_DIV  = 16'h0002;
  localparam logic [15:0] REG_PER  = 16'h0004;
  localparam logic [15:0] REG_DUTY = 16'h0006;

  localparam int CTRL_EXT_CLK  = 0;
  localparam int CTRL_PWM_EN   = 1;
  localparam int CTRL_CNT_EN   = 2;
  localparam int CTRL_CONT     = 3;
  localparam int CTRL_OUT_EN   = 4;
  localparam int CTRL_IRQ_CLR  = 5;
  localparam int CTRL_DUTY_SEL = 6;
  localparam int CTRL_SOFT_RST = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_DIV,
    ST_WR_PER,
    ST_WR_DUTY,
    ST_WR_CTRL,
    ST_WAIT,
    ST_STEP,
    ST_FINISH,
    ST_ERR
  } seq_state_e;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_master_write.sv
// Single Wishbone write: strobe from the req cycle until ack, or until the
// ack timer expires. done/timeout pulse in the cycle after the bus is released.
module wb_master_write #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] adr,
  input  logic [15:0] data,
  input  logic        ack,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [15:0] wb_adr,
  output logic [15:0] wb_data,
  output logic        done,
  output logic        timeout
);

  localparam logic [15:0] TMR_LOAD = 16'(ACK_TIMEOUT - 1);

  logic        pend;
  logic [15:0] tmr;
  logic [15:0] tmr_now;

  // req is a registered one-cycle pulse from the owner, so the bus goes active
  // in the same cycle the owner enters its write state; adr/data are held by it.
  assign cyc     = req | pend;
  assign stb     = cyc;
  assign we      = cyc;
  assign wb_adr  = adr;
  assign wb_data = data;
  assign tmr_now = req ? TMR_LOAD : tmr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      tmr     <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (cyc) begin
        if (ack) begin
          pend <= 1'b0;
          done <= 1'b1;
        end else if (tmr_now == '0) begin
          pend    <= 1'b0;
          timeout <= 1'b1;
        end else begin
          pend <= 1'b1;
          tmr  <= tmr_now - 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Wishbone master that programs the PWM register file, then ramps the duty
// register from start to end duty in saturating steps at a fixed interval.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for i_start; config inputs latched on start
// WR_DIV   | writing divisor
// WR_PER   | writing period
// WR_DUTY  | writing clamped start duty
// WR_CTRL  | writing ctrl
// WAIT     | counting i_step_interval before the next duty step
// STEP     | writing the next saturated duty value
// FINISH   | o_done pulse, back to IDLE
// ERR      | ack timeout seen, back to IDLE
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [15:0] ADR_CTRL    = REG_CTRL,
  parameter logic [15:0] ADR_DIV     = REG_DIV,
  parameter logic [15:0] ADR_PER     = REG_PER,
  parameter logic [15:0] ADR_DUTY    = REG_DUTY
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_ctrl,
  input  logic [15:0] i_divisor,
  input  logic [15:0] i_period,
  input  logic [15:0] i_duty_start,
  input  logic [15:0] i_duty_end,
  input  logic [15:0] i_duty_step,
  input  logic [15:0] i_step_interval,
  input  logic        i_wb_ack,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_cur_duty
);

  seq_state_e  state;
  logic [15:0] cfg_ctrl, cfg_div, cfg_per, cfg_start, cfg_step, cfg_intv;
  logic [15:0] end_duty, cur_duty, wait_cnt, wr_adr, wr_data, step_duty;
  logic        dir_up, wr_req, abort_pend, err_q;
  logic        wr_done, wr_timeout;
  logic [16:0] up_sum;
  logic [15:0] down_gap;
  logic [15:0] start_clamp, end_clamp;

  assign start_clamp = min16(i_duty_start, i_period);
  assign end_clamp   = min16(i_duty_end, i_period);

  // Saturate toward end_duty; the 17-bit sum catches 16-bit wrap on the way up.
  always_comb begin
    up_sum    = {1'b0, cur_duty} + {1'b0, cfg_step};
    down_gap  = cur_duty - end_duty;
    step_duty = end_duty;
    if (cfg_step != 16'd0) begin
      if (dir_up) begin
        if (up_sum <= {1'b0, end_duty}) step_duty = up_sum[15:0];
      end else if (cfg_step <= down_gap) begin
        step_duty = cur_duty - cfg_step;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      cfg_ctrl   <= '0;
      cfg_div    <= '0;
      cfg_per    <= '0;
      cfg_start  <= '0;
      cfg_step   <= '0;
      cfg_intv   <= '0;
      end_duty   <= '0;
      cur_duty   <= '0;
      wait_cnt   <= '0;
      wr_adr     <= '0;
      wr_data    <= '0;
      dir_up     <= 1'b0;
      wr_req     <= 1'b0;
      abort_pend <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_req <= 1'b0;
      if (state != ST_IDLE && i_abort) abort_pend <= 1'b1;
      if (o_wb_cyc && i_wb_ack && (state == ST_WR_DUTY || state == ST_STEP))
        cur_duty <= wr_data;

      unique case (state)
        ST_IDLE: begin
          abort_pend <= 1'b0;
          if (i_start && !i_abort) begin
            cfg_ctrl  <= i_ctrl;
            cfg_div   <= i_divisor;
            cfg_per   <= i_period;
            cfg_start <= start_clamp;
            cfg_step  <= i_duty_step;
            cfg_intv  <= i_step_interval;
            end_duty  <= end_clamp;
            dir_up    <= (end_clamp >= start_clamp);
            err_q     <= 1'b0;
            wr_req    <= 1'b1;
            wr_adr    <= ADR_DIV;
            wr_data   <= i_divisor;
            state     <= ST_WR_DIV;
          end
        end

        ST_WR_DIV, ST_WR_PER, ST_WR_DUTY, ST_WR_CTRL, ST_STEP: begin
          if (wr_timeout) begin
            err_q <= 1'b1;
            state <= ST_ERR;
          end else if (wr_done) begin
            if (abort_pend || i_abort) begin
              state <= ST_IDLE;
            end else if (state == ST_WR_DIV) begin
              wr_req  <= 1'b1;
              wr_adr  <= ADR_PER;
              wr_data <= cfg_per;
              state   <= ST_WR_PER;
            end else if (state == ST_WR_PER) begin
              wr_req  <= 1'b1;
              wr_adr  <= ADR_DUTY;
              wr_data <= cfg_start;
              state   <= ST_WR_DUTY;
            end else if (state == ST_WR_DUTY) begin
              wr_req  <= 1'b1;
              wr_adr  <= ADR_CTRL;
              wr_data <= cfg_ctrl;
              state   <= ST_WR_CTRL;
            end else if (cur_duty == end_duty) begin
              state <= ST_FINISH;
            end else begin
              wait_cnt <= cfg_intv;
              state    <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (i_abort || abort_pend) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 16'd0) begin
            wr_req  <= 1'b1;
            wr_adr  <= ADR_DUTY;
            wr_data <= step_duty;
            state   <= ST_STEP;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end

        ST_FINISH: state <= ST_IDLE;
        ST_ERR:    state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  wb_master_write #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wb_master_write (
    .clk    (i_clk),
    .rst    (i_rst),
    .req    (wr_req),
    .adr    (wr_adr),
    .data   (wr_data),
    .ack    (i_wb_ack),
    .cyc    (o_wb_cyc),
    .stb    (o_wb_stb),
    .we     (o_wb_we),
    .wb_adr (o_wb_adr),
    .wb_data(o_wb_data),
    .done   (wr_done),
    .timeout(wr_timeout)
  );

  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_FINISH);
  assign o_err      = err_q;
  assign o_cur_duty = cur_duty;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: config, ramps, timeout, abort, reset.
module tb_pwm_ramp_sequencer;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_abort, i_wb_ack;
  logic [15:0] i_ctrl, i_divisor, i_period, i_duty_start, i_duty_end;
  logic [15:0] i_duty_step, i_step_interval;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_err;
  logic [15:0] o_wb_adr, o_wb_data, o_cur_duty;

  int checks = 0;
  int failures = 0;

  int ack_delay = 1;
  int nak_adr = -1;
  int ack_wait = 0;

  logic [15:0] log_adr[$];
  logic [15:0] log_dat[$];
  logic [15:0] duty_log[$];
  int          duty_ack_cyc[$];
  int cyc_n = 0;
  int stb_rises = 0;
  int duty_rises = 0;
  int stb_run = 0;
  int done_cnt = 0;
  logic stb_prev = 1'b0;
  logic done_prev = 1'b0;
  logic we_bad = 1'b0;
  logic busy_after_done_bad = 1'b0;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(.ACK_TIMEOUT(16)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_ctrl         (i_ctrl),
    .i_divisor      (i_divisor),
    .i_period       (i_period),
    .i_duty_start   (i_duty_start),
    .i_duty_end     (i_duty_end),
    .i_duty_step    (i_duty_step),
    .i_step_interval(i_step_interval),
    .i_wb_ack       (i_wb_ack),
    .o_wb_cyc       (o_wb_cyc),
    .o_wb_stb       (o_wb_stb),
    .o_wb_we        (o_wb_we),
    .o_wb_adr       (o_wb_adr),
    .o_wb_data      (o_wb_data),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_cur_duty     (o_cur_duty)
  );

  // Slave: acks ack_delay cycles after strobe rises, never for address nak_adr.
  initial begin
    i_wb_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (i_wb_ack) begin
        i_wb_ack = 1'b0;
        ack_wait = 0;
      end else if (o_wb_cyc === 1'b1 && o_wb_stb === 1'b1 && int'(o_wb_adr) != nak_adr) begin
        if (ack_wait == ack_delay) i_wb_ack = 1'b1;
        else ack_wait++;
      end else begin
        ack_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    if (o_wb_cyc === 1'b1 && o_wb_we !== 1'b1) we_bad = 1'b1;
    if (o_wb_stb === 1'b1 && !stb_prev) begin
      stb_rises++;
      stb_run = 0;
      if (o_wb_adr == 16'h0006) duty_rises++;
    end
    if (o_wb_stb === 1'b1) stb_run++;
    stb_prev = (o_wb_stb === 1'b1);
    if (o_wb_cyc === 1'b1 && o_wb_stb === 1'b1 && i_wb_ack) begin
      log_adr.push_back(o_wb_adr);
      log_dat.push_back(o_wb_data);
      if (o_wb_adr == 16'h0006) begin
        duty_log.push_back(o_wb_data);
        duty_ack_cyc.push_back(cyc_n);
      end
    end
    if (o_done === 1'b1) done_cnt++;
    if (done_prev && o_busy === 1'b1) busy_after_done_bad = 1'b1;
    done_prev = (o_done === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    log_adr.delete();
    log_dat.delete();
    duty_log.delete();
    duty_ack_cyc.delete();
    stb_rises = 0;
    duty_rises = 0;
  endtask

  task automatic start_seq(input logic [15:0] div, input logic [15:0] per,
                           input logic [15:0] ds, input logic [15:0] de,
                           input logic [15:0] stp, input logic [15:0] intv,
                           input logic [15:0] ctrl);
    i_divisor = div;
    i_period = per;
    i_duty_start = ds;
    i_duty_end = de;
    i_duty_step = stp;
    i_step_interval = intv;
    i_ctrl = ctrl;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (o_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk_bit(tag, o_busy, 1'b0);
  endtask

  task automatic check_duties(input string tag, input int n,
                              input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] e[4];
    e[0] = v0; e[1] = v1; e[2] = v2; e[3] = v3;
    chk_int({tag, "_count"}, duty_log.size(), n);
    for (int i = 0; i < n && i < duty_log.size(); i++)
      chk16($sformatf("%s_%0d", tag, i), duty_log[i], e[i]);
  endtask

  initial begin
    int n;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_ctrl = '0; i_divisor = '0; i_period = '0; i_duty_start = '0;
    i_duty_end = '0; i_duty_step = '0; i_step_interval = '0;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();

    chk_bit("rst_cyc", o_wb_cyc, 1'b0);
    chk_bit("rst_stb", o_wb_stb, 1'b0);
    chk16("rst_adr", o_wb_adr, 16'h0000);
    chk_bit("rst_busy", o_busy, 1'b0);
    chk_bit("rst_done", o_done, 1'b0);
    chk_bit("rst_err", o_err, 1'b0);
    chk16("rst_cur", o_cur_duty, 16'h0000);

    // Basic config, no ramp
    clear_logs();
    start_seq(16'd4, 16'd100, 16'd0, 16'd0, 16'd1, 16'd0, 16'h0016);
    wait_idle("cfg_idle", 200);
    chk_int("cfg_writes", log_adr.size(), 4);
    if (log_adr.size() == 4) begin
      chk16("cfg_adr0", log_adr[0], 16'h0002); chk16("cfg_dat0", log_dat[0], 16'd4);
      chk16("cfg_adr1", log_adr[1], 16'h0004); chk16("cfg_dat1", log_dat[1], 16'd100);
      chk16("cfg_adr2", log_adr[2], 16'h0006); chk16("cfg_dat2", log_dat[2], 16'd0);
      chk16("cfg_adr3", log_adr[3], 16'h0000); chk16("cfg_dat3", log_dat[3], 16'h0016);
    end
    chk_int("cfg_done_cnt", done_cnt, 1);
    chk_bit("cfg_busy_after_done", busy_after_done_bad, 1'b0);

    // Ramp up with saturation on the last step
    clear_logs();
    start_seq(16'd4, 16'd100, 16'd10, 16'd50, 16'd15, 16'd3, 16'h0016);
    wait_idle("up_idle", 400);
    check_duties("up_duty", 4, 16'd10, 16'd25, 16'd40, 16'd50);
    for (int i = 1; i < duty_ack_cyc.size(); i++)
      chk_bit($sformatf("up_gap_%0d", i), (duty_ack_cyc[i] - duty_ack_cyc[i-1]) >= 4, 1'b1);
    chk16("up_cur", o_cur_duty, 16'd50);
    chk_int("up_done_cnt", done_cnt, 2);

    // Ramp down, start clamped to period
    clear_logs();
    start_seq(16'd4, 16'd100, 16'd200, 16'd5, 16'd40, 16'd0, 16'h0016);
    wait_idle("down_idle", 400);
    check_duties("down_duty", 4, 16'd100, 16'd60, 16'd20, 16'd5);
    chk16("down_cur", o_cur_duty, 16'd5);
    chk_int("down_done_cnt", done_cnt, 3);

    // Ack timeout on the period write
    nak_adr = 4;
    clear_logs();
    start_seq(16'd4, 16'd100, 16'd0, 16'd50, 16'd10, 16'd0, 16'h0016);
    wait_idle("to_idle", 200);
    repeat (5) tick();
    chk_bit("to_err", o_err, 1'b1);
    chk_int("to_stb_cycles", stb_run, 16);
    chk_int("to_acked_writes", log_adr.size(), 1);
    chk_int("to_stb_rises", stb_rises, 2);
    chk_int("to_done_cnt", done_cnt, 3);
    nak_adr = -1;
    start_seq(16'd4, 16'd100, 16'd0, 16'd0, 16'd1, 16'd0, 16'h0016);
    chk_bit("to_err_cleared", o_err, 1'b0);
    wait_idle("to_rerun_idle", 200);
    chk_int("to_rerun_done_cnt", done_cnt, 4);

    // Abort during the second STEP with a slow slave
    ack_delay = 5;
    clear_logs();
    start_seq(16'd4, 16'd100, 16'd0, 16'd100, 16'd10, 16'd2, 16'h0016);
    n = 0;
    while (!(duty_rises == 3 && o_wb_stb === 1'b1) && n < 2000) begin
      tick();
      n++;
    end
    chk_bit("ab_reached_step2", (duty_rises == 3 && o_wb_stb === 1'b1), 1'b1);
    i_abort = 1'b1;
    wait_idle("ab_idle", 200);
    i_abort = 1'b0;
    repeat (10) tick();
    check_duties("ab_duty", 3, 16'd0, 16'd10, 16'd20, 16'd0);
    chk16("ab_cur", o_cur_duty, 16'd20);
    chk_int("ab_duty_rises", duty_rises, 3);
    chk_int("ab_done_cnt", done_cnt, 4);
    chk_bit("ab_busy", o_busy, 1'b0);

    // Reset during WAIT, then a full rerun
    ack_delay = 1;
    clear_logs();
    start_seq(16'd4, 16'd100, 16'd0, 16'd90, 16'd30, 16'd10, 16'h0016);
    n = 0;
    while (duty_log.size() < 2 && n < 500) begin
      tick();
      n++;
    end
    chk_int("rr_reached_wait", duty_log.size(), 2);
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_bit("rr_cyc", o_wb_cyc, 1'b0);
    chk_bit("rr_stb", o_wb_stb, 1'b0);
    chk_bit("rr_we", o_wb_we, 1'b0);
    chk16("rr_adr", o_wb_adr, 16'h0000);
    chk16("rr_data", o_wb_data, 16'h0000);
    chk_bit("rr_busy", o_busy, 1'b0);
    chk_bit("rr_done", o_done, 1'b0);
    chk_bit("rr_err", o_err, 1'b0);
    chk16("rr_cur", o_cur_duty, 16'h0000);
    clear_logs();
    start_seq(16'd4, 16'd100, 16'd0, 16'd90, 16'd30, 16'd0, 16'h0016);
    wait_idle("rr_rerun_idle", 400);
    check_duties("rr_duty", 4, 16'd0, 16'd30, 16'd60, 16'd90);
    chk16("rr_rerun_cur", o_cur_duty, 16'd90);
    chk_int("rr_done_cnt", done_cnt, 5);

    chk_bit("we_with_cyc", we_bad, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
- Wishbone master that configures the PWM subsystem and then ramps its duty cycle, with no CPU involvement per step.
- On start it writes divisor, period, start duty and ctrl into the PWM register file over the existing slave port.
- It then rewrites the duty register in fixed steps at a programmable interval until the end duty is reached.
- Sits beside the CPU master in front of the PWM top (through the system arbiter); used for soft-start and fade profiles.

Parameters:
- ACK_TIMEOUT, 16, cycles to wait for i_wb_ack before aborting with error.
- ADR_CTRL, 16'h0000, ctrl register address.
- ADR_DIV, 16'h0002, divisor register address.
- ADR_PER, 16'h0004, period register address.
- ADR_DUTY, 16'h0006, duty register address.

Ports:
- i_clk  in  1  system clock, the same clock as the PWM register file.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins a sequence when idle.
- i_abort  in  1  level; stops the sequence after the current transfer.
- i_ctrl  in  16  ctrl value written in the config phase.
- i_divisor  in  16  clock divisor value.
- i_period  in  16  PWM period.
- i_duty_start  in  16  first duty value.
- i_duty_end  in  16  final duty value.
- i_duty_step  in  16  magnitude of each duty increment.
- i_step_interval  in  16  idle cycles between duty writes.
- i_wb_ack  in  1  slave acknowledge.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  1  strobe.
- o_wb_we  out  1  write enable; always 1 while o_wb_cyc is high.
- o_wb_adr  out  16  register address.
- o_wb_data  out  16  write data.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse on normal completion.
- o_err  out  1  sticky timeout flag; cleared by the next i_start or by reset.
- o_cur_duty  out  16  last duty value acknowledged by the slave.

Behaviour:
- Reset: all outputs 0, FSM goes to IDLE, counters cleared. Reset has priority over every other input, including mid-transfer.
- Input capture: i_start in IDLE latches all config inputs.
  - end_duty = min(i_duty_end, i_period); start_duty = min(i_duty_start, i_period).
  - Direction is up if end_duty >= start_duty, otherwise down.
  - i_start outside IDLE is ignored.
- States: IDLE -> WR_DIV -> WR_PER -> WR_DUTY -> WR_CTRL -> WAIT -> STEP -> (WAIT | FINISH). FINISH -> IDLE. ERR -> IDLE.
- Write transfer (every WR_*/STEP state):
  - o_wb_cyc, o_wb_stb and o_wb_we go high in the cycle the state is entered; adr/data are held stable until ack.
  - The cycle in which i_wb_ack is sampled high completes the transfer. cyc/stb drop in the next cycle and the FSM advances.
  - Back-to-back transfers have exactly one idle cycle between them.
- Timeout: a 16-bit counter runs while stb is high. If it reaches ACK_TIMEOUT without ack, the FSM drops cyc/stb, sets o_err and goes to ERR, which returns to IDLE the next cycle. o_done is not pulsed.
- WR_DUTY: writes start_duty; o_cur_duty = start_duty on ack.
- WAIT: counts i_step_interval cycles, then enters STEP. A value of 0 enters STEP on the next cycle.
  - If current duty == end_duty on entering WAIT, go to FINISH instead.
- STEP: next = cur ± step, saturated to end_duty with no overshoot and no 16-bit wrap.
  - Up: if cur + step > end_duty or the 17-bit sum carries, next = end_duty.
  - Down: if step > cur - end_duty, next = end_duty.
  - i_duty_step == 0 means next = end_duty, i.e. a single jump.
  - Writes next to ADR_DUTY; on ack, o_cur_duty = next.
- FINISH: o_done = 1 for one cycle, then IDLE.
- Abort:
  - Sampled in any non-IDLE state.
  - If a transfer is in flight, it completes (ack or timeout) first. The FSM then goes to IDLE with no further writes and no o_done.
  - In WAIT, abort goes to IDLE immediately.
  - Abort and ack in the same cycle: the transfer counts as complete and o_cur_duty updates.
- Start and abort in the same cycle in IDLE: start is ignored.

Decomposition:
- Shared package pwm_pkg holds:
  - register address constants (ADR_*);
  - ctrl bit indices (ext_clk 0, pwm_en 1, cnt_en 2, cont 3, out_en 4, irq_clr 5, duty_sel 6, soft_rst 7);
  - FSM state encoding.
- One sub-module, wb_master_write: single-write Wishbone handshake plus timeout counter, with ports req/adr/data -> done/timeout. The sequencer FSM and the step arithmetic stay in the top.

Test Plan:
- Basic config with slave acking 1 cycle after stb, inputs div=4, per=100, start=0, end=0, ctrl=16'h0016:
  - Writes appear in order 0002=4, 0004=100, 0006=0, 0000=0x0016.
  - o_done pulses once; o_busy falls the cycle after o_done.
- Ramp up, start=10, end=50, step=15, interval=3:
  - Duty writes 10, 25, 40, 50 (saturated).
  - At least 3 idle cycles separate consecutive duty acks.
  - Final o_cur_duty = 50.
- Ramp down with clamp, per=100, start=200, end=5, step=40:
  - Duty writes 100, 60, 20, 5; no wrap below 0.
- Timeout: slave never acks on the period write, ACK_TIMEOUT=16:
  - cyc/stb drop after 16 cycles; o_err = 1; no further writes.
  - Next i_start clears o_err.
- Abort mid-transfer: i_abort asserted during the second STEP with ack delayed 5 cycles:
  - That write completes; no further writes; no o_done; returns to IDLE.
- Reset mid-ramp: i_rst for 1 cycle during WAIT:
  - All outputs 0 the next cycle, including o_cur_duty.
  - A subsequent i_start runs a full sequence.
